// File: rtl/pong_key_ctrl.sv
// pong_key_ctrl: turns PS/2 make codes from the keyboard receiver into
// paddle move levels, a start pulse and a generic key strobe.
// Break codes never reach this block, so every move level is kept alive by a
// retriggerable hold timer that typematic repeats refresh while a key is held.
module pong_key_ctrl #(
  parameter int HOLD_CYCLES = 30000000,
  parameter int CNT_W       = 25
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       done,
  input  logic [7:0] tasta,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       start_pulse,
  output logic       key_strobe,
  output logic [7:0] last_key
);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_S     = 8'h1B;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    EXT  = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic       sync1_reg;
  logic       sync2_reg;
  logic       delay_reg;
  logic       done_rise;
  logic       decode_valid;
  logic [3:0] load;
  logic [3:0] hold_level;

  logic       key_strobe_reg;
  logic       start_pulse_reg;
  logic [7:0] last_key_reg;

  // Two-flop synchronizer for done plus a delay flop for edge detection.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      delay_reg <= 1'b0;
    end else begin
      sync1_reg <= done;
      sync2_reg <= sync1_reg;
      delay_reg <= sync2_reg;
    end
  end

  // tasta has been stable for at least two cycles when this edge is seen.
  assign done_rise = sync2_reg & ~delay_reg;

  // Prefix-tracking FSM state register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: an E0 prefix parks in EXT, any other code is decoded and
  // returns to IDLE. The extended flag does not alter the key map, so both
  // states decode identically.
  always_comb begin
    state_next   = state_reg;
    decode_valid = 1'b0;
    if (done_rise) begin
      if (tasta == CODE_EXT) begin
        state_next = EXT;
      end else begin
        decode_valid = 1'b1;
        state_next   = IDLE;
      end
    end
  end

  // Map a decoded code to the hold counter it reloads (0:p1 up, 1:p1 down,
  // 2:p2 up, 3:p2 down); the partner index of a paddle is index ^ 1.
  always_comb begin
    load = '0;
    if (decode_valid) begin
      case (tasta)
        CODE_W:    load[0] = 1'b1;
        CODE_S:    load[1] = 1'b1;
        CODE_UP:   load[2] = 1'b1;
        CODE_DOWN: load[3] = 1'b1;
        default:   load    = '0;
      endcase
    end
  end

  // Strobe, start pulse and last-key registers for the decode cycle.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      key_strobe_reg  <= 1'b0;
      start_pulse_reg <= 1'b0;
      last_key_reg    <= 8'h00;
    end else begin
      key_strobe_reg  <= decode_valid;
      start_pulse_reg <= decode_valid && (tasta == CODE_SPACE);
      if (decode_valid) begin
        last_key_reg <= tasta;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hold
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             level_reg;

      // Own load beats everything (including expiry); the partner's load
      // clears this direction so the newest direction wins.
      always_comb begin
        cnt_next = cnt_reg;
        if (load[gi]) begin
          cnt_next = HOLD_VAL;
        end else if (load[gi ^ 1]) begin
          cnt_next = '0;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      // Counter and its level; the level follows the next count so it rises
      // together with the key strobe and never glitches on a reload.
      always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          level_reg <= (cnt_next != '0);
        end
      end

      assign hold_level[gi] = level_reg;
    end
  endgenerate

  assign p1_up       = hold_level[0];
  assign p1_down     = hold_level[1];
  assign p2_up       = hold_level[2];
  assign p2_down     = hold_level[3];
  assign key_strobe  = key_strobe_reg;
  assign start_pulse = start_pulse_reg;
  assign last_key    = last_key_reg;

endmodule

// File: tb/tb_pong_key_ctrl.sv
// Testbench for pong_key_ctrl with a short hold time. Expected strobe
// results are queued when a code is driven and consumed when key_strobe fires.
module tb_pong_key_ctrl;

  localparam int HOLD = 100;

  typedef struct {
    logic [7:0] key;
    logic       start;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       done  = 1'b0;
  logic [7:0] tasta = 8'h00;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic       start_pulse, key_strobe;
  logic [7:0] last_key;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic p1_both_seen = 1'b0;
  logic p2_both_seen = 1'b0;

  pong_key_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clock       (clock),
    .rst         (rst),
    .done        (done),
    .tasta       (tasta),
    .p1_up       (p1_up),
    .p1_down     (p1_down),
    .p2_up       (p2_up),
    .p2_down     (p2_down),
    .start_pulse (start_pulse),
    .key_strobe  (key_strobe),
    .last_key    (last_key)
  );

  always #5 clock = ~clock;

  // Scoreboard consumer: every strobe must match the oldest queued code.
  always @(negedge clock) begin
    exp_t e;
    if (key_strobe === 1'b1) begin
      total_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL strobe_unexpected: last_key=%h start=%b, required no strobe", last_key, start_pulse);
      end else begin
        e = sb_q.pop_front();
        if (last_key !== e.key || start_pulse !== e.start) begin
          $display("FAIL strobe_data: last_key=%h start=%b, required last_key=%h start=%b",
                   last_key, start_pulse, e.key, e.start);
        end else begin
          pass_cnt++;
          $display("strobe ok: last_key=%h start=%b", last_key, start_pulse);
        end
      end
    end else if (start_pulse === 1'b1) begin
      total_cnt++;
      $display("FAIL start_without_strobe: start_pulse=1, required 0");
    end
    if (p1_up === 1'b1 && p1_down === 1'b1) p1_both_seen = 1'b1;
    if (p2_up === 1'b1 && p2_down === 1'b1) p2_both_seen = 1'b1;
  end

  // Raise done with a code, queue the expected strobe, return on the decode
  // cycle (third negedge after done rises) with done already lowered.
  task automatic drive_code(input logic [7:0] code);
    exp_t e;
    @(negedge clock);
    done  = 1'b1;
    tasta = code;
    if (code != 8'hE0) begin
      e.key   = code;
      e.start = (code == 8'h29);
      sb_q.push_back(e);
    end
    repeat (3) @(negedge clock);
    done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    idle_cycles(3);
    total_cnt++;
    if ({p1_up, p1_down, p2_up, p2_down, start_pulse, key_strobe, last_key} !== 14'h0) begin
      $display("FAIL reset_outputs: got %b_%h, required all 0", {p1_up, p1_down, p2_up, p2_down, start_pulse, key_strobe}, last_key);
    end else begin
      pass_cnt++;
      $display("reset ok");
    end
    rst = 1'b1;
    idle_cycles(5);
  endtask

  task automatic test_single_w;
    int hi;
    logic other;
    exp_t e;
    @(negedge clock);
    done  = 1'b1;
    tasta = 8'h1D;
    e.key = 8'h1D; e.start = 1'b0;
    sb_q.push_back(e);
    idle_cycles(2);
    total_cnt++;
    if (p1_up !== 1'b0) $display("FAIL w_early: p1_up=%b, required 0 before decode", p1_up);
    else pass_cnt++;
    idle_cycles(1);
    done = 1'b0;
    total_cnt++;
    if (p1_up !== 1'b1) $display("FAIL w_rise: p1_up=%b, required 1 on decode cycle", p1_up);
    else pass_cnt++;
    hi = 1;
    other = 1'b0;
    for (int k = 0; k < HOLD + 20; k++) begin
      @(negedge clock);
      if (p1_down | p2_up | p2_down) other = 1'b1;
      if (p1_up === 1'b1) hi++;
      else break;
    end
    total_cnt++;
    if (hi !== HOLD) $display("FAIL w_hold_len: p1_up high %0d cycles, required %0d", hi, HOLD);
    else pass_cnt++;
    total_cnt++;
    if (other !== 1'b0) $display("FAIL w_other_moves: other move seen=%b, required 0", other);
    else pass_cnt++;
    $display("single W: p1_up high %0d cycles", hi);
  endtask

  task automatic test_retrigger;
    int hi;
    logic gap;
    gap = 1'b0;
    for (int r = 0; r < 3; r++) begin
      drive_code(8'h1D);
      if (p1_up !== 1'b1) gap = 1'b1;
      if (r < 2) begin
        for (int k = 0; k < 56; k++) begin
          @(negedge clock);
          if (p1_up !== 1'b1) gap = 1'b1;
        end
      end
    end
    total_cnt++;
    if (gap !== 1'b0) $display("FAIL retrig_gap: p1_up dropped=%b, required continuous", gap);
    else pass_cnt++;
    hi = 1;
    for (int k = 0; k < HOLD + 20; k++) begin
      @(negedge clock);
      if (p1_up === 1'b1) hi++;
      else break;
    end
    total_cnt++;
    if (hi !== HOLD) $display("FAIL retrig_tail: p1_up high %0d cycles after last decode, required %0d", hi, HOLD);
    else pass_cnt++;
    $display("retrigger: tail %0d cycles", hi);
  endtask

  task automatic test_override;
    drive_code(8'h1D);
    idle_cycles(16);
    total_cnt++;
    if (p1_up !== 1'b1 || p1_down !== 1'b0) $display("FAIL override_pre: up=%b down=%b, required 1/0", p1_up, p1_down);
    else pass_cnt++;
    drive_code(8'h1B);
    total_cnt++;
    if (p1_up !== 1'b0 || p1_down !== 1'b1) $display("FAIL override_switch: up=%b down=%b, required 0/1", p1_up, p1_down);
    else pass_cnt++;
    idle_cycles(HOLD + 5);
    total_cnt++;
    if (p1_down !== 1'b0) $display("FAIL override_expire: p1_down=%b, required 0", p1_down);
    else pass_cnt++;
    $display("override: done");
  endtask

  task automatic test_extended_up;
    int hi;
    drive_code(8'hE0);
    idle_cycles(3);
    drive_code(8'h75);
    total_cnt++;
    if (p2_up !== 1'b1 || p1_up !== 1'b0 || p1_down !== 1'b0 || p2_down !== 1'b0)
      $display("FAIL ext_up_levels: p1=%b%b p2=%b%b, required p1=00 p2=10", p1_up, p1_down, p2_up, p2_down);
    else pass_cnt++;
    hi = 1;
    for (int k = 0; k < HOLD + 20; k++) begin
      @(negedge clock);
      if (p2_up === 1'b1) hi++;
      else break;
    end
    total_cnt++;
    if (hi !== HOLD) $display("FAIL ext_up_len: p2_up high %0d cycles, required %0d", hi, HOLD);
    else pass_cnt++;
    $display("extended up: p2_up high %0d cycles", hi);
  endtask

  task automatic test_space_unknown;
    drive_code(8'h29);
    @(negedge clock);
    total_cnt++;
    if (start_pulse !== 1'b0) $display("FAIL start_len: start_pulse=%b one cycle later, required 0", start_pulse);
    else pass_cnt++;
    idle_cycles(3);
    drive_code(8'h5A);
    total_cnt++;
    if ({p1_up, p1_down, p2_up, p2_down, start_pulse} !== 5'b0)
      $display("FAIL unknown_moves: moves/start=%b, required 00000", {p1_up, p1_down, p2_up, p2_down, start_pulse});
    else pass_cnt++;
    $display("space/unknown: done");
  endtask

  task automatic test_back_to_back;
    drive_code(8'hE0);
    idle_cycles(2);
    drive_code(8'hE0);
    idle_cycles(2);
    drive_code(8'h1D);
    total_cnt++;
    if (p1_up !== 1'b1) $display("FAIL double_prefix: p1_up=%b, required 1", p1_up);
    else pass_cnt++;
    idle_cycles(HOLD + 5);
    $display("double prefix: done");
  endtask

  task automatic test_reset_mid_hold;
    logic busy;
    drive_code(8'h72);
    idle_cycles(49);
    total_cnt++;
    if (p2_down !== 1'b1) $display("FAIL midhold_pre: p2_down=%b, required 1", p2_down);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (p2_down !== 1'b0 || last_key !== 8'h00)
      $display("FAIL midhold_async: p2_down=%b last_key=%h, required 0/00", p2_down, last_key);
    else pass_cnt++;
    idle_cycles(5);
    rst = 1'b1;
    busy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if ({p1_up, p1_down, p2_up, p2_down, start_pulse, key_strobe} !== 6'b0) busy = 1'b1;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL midhold_quiet: activity=%b after release, required 0", busy);
    else pass_cnt++;
    $display("reset mid-hold: done");
  endtask

  task automatic test_final_state;
    total_cnt++;
    if (sb_q.size() !== 0) $display("FAIL sb_drain: %0d strobes missing, required 0", sb_q.size());
    else pass_cnt++;
    total_cnt++;
    if (p1_both_seen !== 1'b0 || p2_both_seen !== 1'b0)
      $display("FAIL exclusive: both-dir p1=%b p2=%b, required 0/0", p1_both_seen, p2_both_seen);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_w();
    test_retrigger();
    test_override();
    test_extended_up();
    test_space_unknown();
    test_back_to_back();
    test_reset_mid_hold();
    test_final_state();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pong_key_ctrl.md
Name: pong_key_ctrl

Overview:
- Consumer stage directly downstream of the PS/2 keyboard receiver in the PONG design.
- Takes the receiver's `done`/`tasta` outputs (make codes only; the receiver already swallows F0 break sequences) into the system clock domain.
- Decodes paddle and start keys into per-paddle move levels. Because break codes never arrive, each move level is held by a retriggerable timer that the keyboard's typematic repeats keep refreshed while the key is held.

Parameters:
- HOLD_CYCLES, 30000000: cycles a move output stays high after its last make code (600 ms at 50 MHz, longer than the 500 ms typematic delay).
- CNT_W, 25: hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clock  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-low.
- done  in  1  receiver frame-valid level, asynchronous to clock; rises once per accepted make code.
- tasta  in  8  receiver scan code; stable while done is high.
- p1_up  out  1  left paddle up level.
- p1_down  out  1  left paddle down level.
- p2_up  out  1  right paddle up level.
- p2_down  out  1  right paddle down level.
- start_pulse  out  1  one-cycle pulse per Space make code.
- key_strobe  out  1  one-cycle pulse per accepted non-prefix code.
- last_key  out  8  last accepted non-prefix code.

Behaviour:
- Reset, asynchronous on rst=0. All outputs 0, last_key=8'h00, all hold counters 0, sync flops 0, FSM in IDLE.
- Input sync:
  - done passes through a 2-flop synchronizer plus a delay flop.
  - An event is a rising edge of the synchronized done.
  - tasta is sampled on the event cycle. It is stable, because done has been high for at least 2 cycles by then.
  - Events are accepted 3 clocks after done rises, including the detect cycle.
- FSM states:
  - IDLE: event with code E0 goes to EXT with no outputs; any other event is decoded with ext=0.
  - EXT: the next event is decoded with ext=1, then the FSM returns to IDLE. An E0 event while in EXT stays in EXT with no action.
- The ext flag does not change the key map. Extended and keypad codes map identically.
- Key map:
  - 1D (W) = p1 up; 1B (S) = p1 down.
  - 75 (Up / KP8) = p2 up; 72 (Down / KP2) = p2 down.
  - 29 (Space) = start.
  - Any other code: only key_strobe and last_key update.
- Decode cycle, the cycle after the event, for every non-E0 code:
  - key_strobe=1 for one cycle and last_key=code.
  - Space: start_pulse=1 for that same cycle.
- Hold counters (four, CNT_W bits each):
  - A matching code loads its own counter with HOLD_CYCLES and clears the opposite counter of the same paddle, so the newest direction wins and up/down never both assert.
  - Otherwise a nonzero counter decrements by 1 per cycle and saturates at 0.
  - Output level = (counter != 0), registered. It rises on the decode cycle and falls exactly HOLD_CYCLES cycles after its last load.
- Retrigger: a repeat code while the counter is nonzero reloads it to HOLD_CYCLES with no output glitch.
- Paddles are independent: a p1 event never touches the p2 counters, and vice versa.
- Simultaneous load and expiry on the same cycle: the load wins.
- done still high at reset release: the synchronizer resets to 0, so an already-high done produces one event after release. This is accepted behaviour.
- Reset mid-hold: outputs drop asynchronously. After release the block stays idle until the next event.
- Codes arriving faster than 3 clocks apart cannot occur; the PS/2 frame is about 1 ms or longer.

Test Plan (HOLD_CYCLES=100, CNT_W=8):
- Single W press: done rises with tasta=1D.
  - p1_up=1 from cycle 4 after the done edge for exactly 100 cycles.
  - key_strobe pulses once with last_key=1D.
  - Other move outputs stay 0.
- Retrigger: 1D events 60 cycles apart, three times.
  - p1_up stays high continuously.
  - p1_up falls 100 cycles after the third decode.
- Direction override: 1D, then 1B 20 cycles later.
  - p1_up drops on the 1B decode cycle and p1_down rises on the same cycle.
  - p1_up and p1_down are never both 1.
- Extended Up: event E0, then event 75.
  - No key_strobe on E0.
  - On 75: p2_up held 100 cycles, last_key=75, key_strobe pulses once.
  - p1 outputs are unaffected.
- Space and unknown code: 29 gives start_pulse exactly 1 cycle; 5A gives key_strobe with last_key=5A and no move or start output.
- Reset mid-hold: rst=0 for 5 cycles at count 50 of a p2_down hold.
  - Outputs go 0 immediately and last_key=00.
  - No activity after release until a new done edge.
